// File: rtl/dram_cmd_responder.sv
// DDR5 device-side command responder: per-bank state/timing checks and data-burst windows.
module dram_cmd_responder #(
    parameter int unsigned TRCD     = 39,
    parameter int unsigned TRP      = 39,
    parameter int unsigned TRAS     = 76,
    parameter int unsigned TRC      = 115,
    parameter int unsigned TRTP     = 18,
    parameter int unsigned TWR      = 30,
    parameter int unsigned TCAS     = 40,
    parameter int unsigned CWL      = 38,
    parameter int unsigned TBURST   = 8,
    parameter int unsigned BQ_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    input  logic [2:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    input  logic [9:0]  cmd_col,
    output logic        err_valid,
    output logic [3:0]  err_code,
    output logic        rd_valid,
    output logic        wr_strobe,
    output logic [2:0]  burst_bg,
    output logic [1:0]  burst_ba,
    output logic [9:0]  burst_col,
    output logic [31:0] bank_open
);

    localparam int unsigned NumBanks = 32;
    localparam int unsigned CntW     = 8;
    localparam int unsigned TWrPre   = CWL + TBURST + TWR;
    localparam int unsigned PtrW     = (BQ_DEPTH > 1) ? $clog2(BQ_DEPTH) : 1;
    localparam int unsigned CntQW    = $clog2(BQ_DEPTH + 1);

    localparam logic [2:0] CmdNop = 3'd0;
    localparam logic [2:0] CmdAct = 3'd1;
    localparam logic [2:0] CmdRd  = 3'd2;
    localparam logic [2:0] CmdWr  = 3'd3;
    localparam logic [2:0] CmdPre = 3'd4;

    typedef enum logic {BankIdle = 1'b0, BankActive = 1'b1} bank_state_e;

    bank_state_e     bank_q     [NumBanks];
    logic [15:0]     open_row_q [NumBanks];
    logic [CntW-1:0] act_cnt_q  [NumBanks];
    logic [CntW-1:0] rw_cnt_q   [NumBanks];
    logic [CntW-1:0] pre_cnt_q  [NumBanks];

    logic [15:0]      now_q;
    logic [15:0]      last_end_q;
    logic             fifo_wr_q    [BQ_DEPTH];
    logic [15:0]      fifo_start_q [BQ_DEPTH];
    logic [2:0]       fifo_bg_q    [BQ_DEPTH];
    logic [1:0]       fifo_ba_q    [BQ_DEPTH];
    logic [9:0]       fifo_col_q   [BQ_DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q, rd_nxt, wr_nxt, act_idx;
    logic [CntQW-1:0] count_q;

    logic [4:0]          bidx;
    logic                sel_open, is_act, is_rd, is_wr, is_pre;
    logic                accept, push, pop, full, conflict, act_valid;
    logic [3:0]          code_d;
    logic [15:0]         start, bus_diff, next_cyc, head_diff, next_diff;
    logic [NumBanks-1:0] bank_hit;

    // Saturating down-count; a new load only ever lengthens the remaining wait.
    function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cur, input logic load,
                                                 input logic [CntW-1:0] val);
        logic [CntW-1:0] dec;
        dec = (cur == '0) ? '0 : cur - 1'b1;
        return (load && val > dec) ? val : dec;
    endfunction

    assign bidx     = {cmd_bg, cmd_ba};
    assign sel_open = (bank_q[bidx] == BankActive);
    assign is_act   = (cmd == CmdAct);
    assign is_rd    = (cmd == CmdRd);
    assign is_wr    = (cmd == CmdWr);
    assign is_pre   = (cmd == CmdPre);

    assign rd_nxt = (rd_ptr_q == PtrW'(BQ_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    assign wr_nxt = (wr_ptr_q == PtrW'(BQ_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);

    // Burst timing: next_cyc is the data cycle the registered outputs will represent.
    assign next_cyc  = now_q + 16'd1;
    assign head_diff = next_cyc - fifo_start_q[rd_ptr_q];
    assign next_diff = next_cyc - fifo_start_q[rd_nxt];
    assign pop       = (count_q != '0) && (head_diff == 16'(TBURST));
    assign full      = ((count_q - CntQW'(pop)) == CntQW'(BQ_DEPTH));
    assign start     = now_q + (is_rd ? 16'(TCAS) : 16'(CWL));
    assign bus_diff  = start - last_end_q;
    // Modular compare: a negative distance to the last scheduled end means overlap.
    assign conflict  = (count_q != '0) && bus_diff[15];

    // Command check in priority order; first failing code wins.
    always_comb begin
        code_d = 4'd0;
        if (cmd_valid) begin
            case (cmd)
                CmdNop: code_d = 4'd0;
                CmdAct: begin
                    if (sel_open)                        code_d = 4'd1;
                    else if (act_cnt_q[bidx] != '0)      code_d = 4'd2;
                end
                CmdRd, CmdWr: begin
                    if (!sel_open)                       code_d = 4'd3;
                    else if (rw_cnt_q[bidx] != '0)       code_d = 4'd4;
                    else if (full)                       code_d = 4'd8;
                    else if (conflict)                   code_d = 4'd7;
                end
                CmdPre: begin
                    if (sel_open && pre_cnt_q[bidx] != '0) code_d = 4'd5;
                end
                default: code_d = 4'd6;
            endcase
        end
    end

    assign accept = cmd_valid && (code_d == 4'd0) && (cmd != CmdNop);
    assign push   = accept && (is_rd || is_wr);

    // One-hot select of the bank touched by an accepted command.
    always_comb begin
        bank_hit = '0;
        if (accept) bank_hit[bidx] = 1'b1;
    end

    // Pick the burst owning the next data cycle: the head, or its back-to-back successor.
    always_comb begin
        act_valid = 1'b0;
        act_idx   = rd_ptr_q;
        if (count_q != '0 && head_diff < 16'(TBURST)) begin
            act_valid = 1'b1;
        end else if (count_q > CntQW'(1) && next_diff < 16'(TBURST)) begin
            act_valid = 1'b1;
            act_idx   = rd_nxt;
        end
    end

    // Per-bank timing counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NumBanks; b++) begin
                act_cnt_q[b] <= '0;
                rw_cnt_q[b]  <= '0;
                pre_cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                act_cnt_q[b] <= next_cnt(act_cnt_q[b],
                                         bank_hit[b] && (is_act || (is_pre && sel_open)),
                                         is_act ? CntW'(TRC - 1) : CntW'(TRP - 1));
                rw_cnt_q[b]  <= next_cnt(rw_cnt_q[b], bank_hit[b] && is_act, CntW'(TRCD - 1));
                pre_cnt_q[b] <= next_cnt(pre_cnt_q[b], bank_hit[b] && (is_act || is_rd || is_wr),
                                         is_act ? CntW'(TRAS - 1) :
                                         is_rd  ? CntW'(TRTP - 1) : CntW'(TWrPre - 1));
            end
        end
    end

    // Bank FSM: IDLE -ACT-> ACTIVE -PRE-> IDLE; PRE to an idle bank changes nothing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NumBanks; b++) begin
                bank_q[b]     <= BankIdle;
                open_row_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (bank_hit[b] && is_act) begin
                    bank_q[b]     <= BankActive;
                    open_row_q[b] <= cmd_row;
                end else if (bank_hit[b] && is_pre) begin
                    bank_q[b] <= BankIdle;
                end
            end
        end
    end

    // Bank-open vector straight from the bank state registers.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) bank_open[b] = (bank_q[b] == BankActive);
    end

    // Pending-burst FIFO, free-running cycle counter and last scheduled burst end.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            now_q      <= '0;
            last_end_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < BQ_DEPTH; i++) begin
                fifo_wr_q[i]    <= 1'b0;
                fifo_start_q[i] <= '0;
                fifo_bg_q[i]    <= '0;
                fifo_ba_q[i]    <= '0;
                fifo_col_q[i]   <= '0;
            end
        end else begin
            now_q <= now_q + 16'd1;
            if (push) begin
                fifo_wr_q[wr_ptr_q]    <= is_wr;
                fifo_start_q[wr_ptr_q] <= start;
                fifo_bg_q[wr_ptr_q]    <= cmd_bg;
                fifo_ba_q[wr_ptr_q]    <= cmd_ba;
                fifo_col_q[wr_ptr_q]   <= cmd_col;
                wr_ptr_q               <= wr_nxt;
                last_end_q             <= start + 16'(TBURST);
            end
            if (pop) rd_ptr_q <= rd_nxt;
            count_q <= count_q + CntQW'(push) - CntQW'(pop);
        end
    end

    // Registered error pulse and data-bus window outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_code  <= 4'd0;
            rd_valid  <= 1'b0;
            wr_strobe <= 1'b0;
            burst_bg  <= '0;
            burst_ba  <= '0;
            burst_col <= '0;
        end else begin
            err_valid <= (code_d != 4'd0);
            if (code_d != 4'd0) err_code <= code_d;
            rd_valid  <= act_valid && !fifo_wr_q[act_idx];
            wr_strobe <= act_valid && fifo_wr_q[act_idx];
            burst_bg  <= act_valid ? fifo_bg_q[act_idx]  : 3'd0;
            burst_ba  <= act_valid ? fifo_ba_q[act_idx]  : 2'd0;
            burst_col <= act_valid ? fifo_col_q[act_idx] : 10'd0;
        end
    end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder: directed scenarios plus random traffic vs a model.
module tb_dram_cmd_responder;

    localparam int TRCD = 39, TRP = 39, TRAS = 76, TRC = 115, TRTP = 18, TWR = 30;
    localparam int TCAS = 40, CWL = 38, TBURST = 8, BQ_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n, cmd_valid;
    logic [2:0]  cmd, cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        err_valid, rd_valid, wr_strobe;
    logic [3:0]  err_code;
    logic [2:0]  burst_bg;
    logic [1:0]  burst_ba;
    logic [9:0]  burst_col;
    logic [31:0] bank_open;

    dram_cmd_responder dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg),
        .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col), .err_valid(err_valid),
        .err_code(err_code), .rd_valid(rd_valid), .wr_strobe(wr_strobe), .burst_bg(burst_bg),
        .burst_ba(burst_ba), .burst_col(burst_col), .bank_open(bank_open)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;  // index of the next rising edge

    // Reference model: last event time per bank and the list of scheduled bursts.
    typedef struct {bit is_wr; int start; int stop; int bg; int ba; int col;} burst_t;
    int     m_act[32], m_pre[32], m_rd[32], m_wr[32];
    bit     m_open[32];
    burst_t bq[$];
    int     m_last_end;
    bit          e_err_valid, e_rd, e_wr;
    logic [3:0]  e_err_code;
    logic [31:0] e_open;
    logic [2:0]  e_bg;
    logic [1:0]  e_ba;
    logic [9:0]  e_col;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_act[i] = -100000; m_pre[i] = -100000; m_rd[i] = -100000; m_wr[i] = -100000;
            m_open[i] = 0;
        end
        bq.delete();
        m_last_end = -100000;
        e_err_valid = 0; e_err_code = 4'd0;
    endfunction

    function automatic int model_check(int n, int c, int b);
        int pend;
        if (c == 0) return 0;
        if (c > 4) return 6;
        if (c == 1) begin
            if (m_open[b]) return 1;
            if (n - m_act[b] < TRC || n - m_pre[b] < TRP) return 2;
            return 0;
        end
        if (c == 4) begin
            if (m_open[b] && (n - m_act[b] < TRAS || n - m_rd[b] < TRTP ||
                              n - m_wr[b] < CWL + TBURST + TWR)) return 5;
            return 0;
        end
        if (!m_open[b]) return 3;
        if (n - m_act[b] < TRCD) return 4;
        pend = 0;
        foreach (bq[i]) if (bq[i].stop > n + 1) pend++;
        if (pend >= BQ_DEPTH) return 8;
        if (n + ((c == 2) ? TCAS : CWL) < m_last_end) return 7;
        return 0;
    endfunction

    function automatic void model_apply(int n, int c, int bg, int ba, int col);
        int b;
        burst_t nb;
        b = bg * 4 + ba;
        if (c == 1) begin
            m_open[b] = 1; m_act[b] = n;
        end else if (c == 2 || c == 3) begin
            if (c == 2) m_rd[b] = n; else m_wr[b] = n;
            nb.is_wr = (c == 3);
            nb.start = n + ((c == 2) ? TCAS : CWL);
            nb.stop  = nb.start + TBURST;
            nb.bg = bg; nb.ba = ba; nb.col = col;
            bq.push_back(nb);
            m_last_end = nb.stop;
        end else if (c == 4 && m_open[b]) begin
            m_open[b] = 0; m_pre[b] = n;
        end
    endfunction

    // Drive one command for edge cyc, advance the model, return #1 after the edge.
    task automatic tick(input int v, input int c, input int bg, input int ba, input int row,
                        input int col);
        int n, code;
        n = cyc;
        cmd_valid = (v != 0); cmd = 3'(c); cmd_bg = 3'(bg); cmd_ba = 2'(ba);
        cmd_row = 16'(row); cmd_col = 10'(col);
        while (bq.size() > 0 && bq[0].stop <= n + 1) void'(bq.pop_front());
        code = (v != 0) ? model_check(n, c, bg * 4 + ba) : 0;
        e_err_valid = (code != 0);
        if (code != 0) e_err_code = 4'(code);
        else if (v != 0) model_apply(n, c, bg, ba, col);
        for (int i = 0; i < 32; i++) e_open[i] = m_open[i];
        e_rd = 0; e_wr = 0; e_bg = 0; e_ba = 0; e_col = 0;
        foreach (bq[i]) begin
            if (bq[i].start <= n + 1 && n + 1 < bq[i].stop) begin
                e_rd = !bq[i].is_wr; e_wr = bq[i].is_wr;
                e_bg = 3'(bq[i].bg); e_ba = 2'(bq[i].ba); e_col = 10'(bq[i].col);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        cmd_valid = 1'b0;
    endtask

    // Idle until the next edge index is t; outputs then show cycle t.
    task automatic run_to(input int t);
        while (cyc < t) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) begin @(posedge clock); cyc++; end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({err_valid, err_code, rd_valid, wr_strobe, burst_bg, burst_ba, burst_col} !== 21'd0) begin
            failures++; $display("FAIL reset_outputs: got %b want 0", {err_valid, err_code,
                                 rd_valid, wr_strobe, burst_bg, burst_ba, burst_col});
        end
        checks++;
        if (bank_open !== 32'd0) begin
            failures++; $display("FAIL reset_bank_open: got %h want 0", bank_open);
        end
    endtask

    task automatic test_read_basic();
        int b;
        do_reset(); b = cyc;
        run_to(b + 10);
        checks++; if (bank_open[9] !== 1'b0) begin failures++; $display("FAIL t1_open_pre: got %b want 0", bank_open[9]); end
        tick(1, 1, 2, 1, 'h1A2B, 0);
        checks++; if (bank_open !== 32'h200) begin failures++; $display("FAIL t1_open: got %h want 200", bank_open); end
        run_to(b + 49);
        tick(1, 2, 2, 1, 0, 'h040);
        checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL t1_rd_err: got %b want 0", err_valid); end
        run_to(b + 88);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL t1_rd_early: got %b want 0", rd_valid); end
        run_to(b + 89);
        checks++;
        if ({rd_valid, burst_bg, burst_ba, burst_col} !== {1'b1, 3'd2, 2'd1, 10'h040}) begin
            failures++; $display("FAIL t1_rd_first: got %b %0d %0d %h want 1 2 1 040",
                                 rd_valid, burst_bg, burst_ba, burst_col);
        end
        run_to(b + 96);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL t1_rd_last: got %b want 1", rd_valid); end
        run_to(b + 97);
        checks++;
        if ({rd_valid, burst_col} !== 11'd0) begin
            failures++; $display("FAIL t1_rd_end: got %b %h want 0 000", rd_valid, burst_col);
        end
    endtask

    task automatic test_trcd();
        int b;
        do_reset(); b = cyc;
        run_to(b + 10); tick(1, 1, 2, 1, 'h1A2B, 0);
        run_to(b + 48); tick(1, 2, 2, 1, 0, 'h040);
        checks++;
        if ({err_valid, err_code} !== {1'b1, 4'd4}) begin
            failures++; $display("FAIL t2_trcd: got %b %0d want 1 4", err_valid, err_code);
        end
        tick(1, 2, 2, 1, 0, 'h040);
        checks++;
        if ({err_valid, err_code} !== {1'b0, 4'd4}) begin
            failures++; $display("FAIL t2_accept_hold: got %b %0d want 0 4", err_valid, err_code);
        end
        run_to(b + 88);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL t2_no_early_rd: got %b want 0", rd_valid); end
        run_to(b + 89);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL t2_rd: got %b want 1", rd_valid); end
    endtask

    task automatic test_tras_trc();
        int b;
        do_reset(); b = cyc;
        tick(1, 1, 0, 0, 5, 0);
        run_to(b + 75); tick(1, 4, 0, 0, 0, 0);
        checks++;
        if ({err_valid, err_code, bank_open[0]} !== {1'b1, 4'd5, 1'b1}) begin
            failures++; $display("FAIL t3_tras: got %b %0d %b want 1 5 1", err_valid, err_code, bank_open[0]);
        end
        tick(1, 4, 0, 0, 0, 0);
        checks++;
        if ({err_valid, bank_open[0]} !== 2'b00) begin
            failures++; $display("FAIL t3_pre_ok: got %b %b want 0 0", err_valid, bank_open[0]);
        end
        run_to(b + 114); tick(1, 1, 0, 0, 7, 0);
        checks++;
        if ({err_valid, err_code} !== {1'b1, 4'd2}) begin
            failures++; $display("FAIL t3_trc: got %b %0d want 1 2", err_valid, err_code);
        end
        tick(1, 1, 0, 0, 7, 0);
        checks++;
        if ({err_valid, bank_open[0]} !== 2'b01) begin
            failures++; $display("FAIL t3_act_ok: got %b %b want 0 1", err_valid, bank_open[0]);
        end
    endtask

    task automatic test_state_errors();
        do_reset();
        tick(1, 2, 3, 0, 0, 1);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd3}) begin failures++; $display("FAIL t4_rd_idle: got %b %0d want 1 3", err_valid, err_code); end
        tick(1, 6, 3, 0, 0, 0);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd6}) begin failures++; $display("FAIL t4_illegal6: got %b %0d want 1 6", err_valid, err_code); end
        tick(1, 1, 3, 0, 9, 0);
        checks++; if ({err_valid, bank_open} !== {1'b0, 32'h1000}) begin failures++; $display("FAIL t4_act: got %b %h want 0 1000", err_valid, bank_open); end
        tick(1, 1, 3, 0, 9, 0);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd1}) begin failures++; $display("FAIL t4_act_open: got %b %0d want 1 1", err_valid, err_code); end
        tick(1, 7, 3, 0, 0, 0);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd6}) begin failures++; $display("FAIL t4_illegal7: got %b %0d want 1 6", err_valid, err_code); end
        tick(1, 4, 5, 1, 0, 0);
        checks++; if ({err_valid, err_code, bank_open} !== {1'b0, 4'd6, 32'h1000}) begin failures++; $display("FAIL t4_pre_idle: got %b %0d %h want 0 6 1000", err_valid, err_code, bank_open); end
    endtask

    task automatic test_bus_conflict();
        int b;
        bit want;
        do_reset(); b = cyc;
        tick(1, 1, 4, 2, 1, 0);
        run_to(b + 100); tick(1, 2, 4, 2, 0, 'h11);
        run_to(b + 104); tick(1, 2, 4, 2, 0, 'h12);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd7}) begin failures++; $display("FAIL t5_conflict: got %b %0d want 1 7", err_valid, err_code); end
        run_to(b + 108); tick(1, 2, 4, 2, 0, 'h13);
        checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL t5_b2b_accept: got %b want 0", err_valid); end
        for (int c = 139; c <= 156; c++) begin
            run_to(b + c);
            want = (c >= 140 && c <= 155);
            checks++;
            if (rd_valid !== want) begin failures++; $display("FAIL t5_b2b_c%0d: got %b want %b", c, rd_valid, want); end
        end
        do_reset(); b = cyc;
        tick(1, 1, 4, 2, 1, 0);
        run_to(b + 100); tick(1, 2, 4, 2, 0, 'h21);
        run_to(b + 109); tick(1, 3, 4, 2, 0, 'h22);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd7}) begin failures++; $display("FAIL t5_wr_early: got %b %0d want 1 7", err_valid, err_code); end
        tick(1, 3, 4, 2, 0, 'h22);
        checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL t5_wr_edge: got %b want 0", err_valid); end
        run_to(b + 147);
        checks++; if ({rd_valid, wr_strobe} !== 2'b10) begin failures++; $display("FAIL t5_rd147: got %b%b want 10", rd_valid, wr_strobe); end
        run_to(b + 148);
        checks++; if ({rd_valid, wr_strobe, burst_col} !== {2'b01, 10'h22}) begin failures++; $display("FAIL t5_wr148: got %b%b %h want 01 022", rd_valid, wr_strobe, burst_col); end
        run_to(b + 156);
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL t5_wr156: got %b want 0", wr_strobe); end
    endtask

    task automatic test_fifo_full();
        int b;
        do_reset(); b = cyc;
        tick(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin run_to(b + 40 + 8 * k); tick(1, 2, 0, 0, 0, k); end
        run_to(b + 72); tick(1, 2, 0, 0, 0, 9);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd8}) begin failures++; $display("FAIL fifo_full: got %b %0d want 1 8", err_valid, err_code); end
        run_to(b + 86); tick(1, 3, 0, 0, 0, 9);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd8}) begin failures++; $display("FAIL fifo_full_late: got %b %0d want 1 8", err_valid, err_code); end
        tick(1, 2, 0, 0, 0, 9);
        checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL fifo_push_pop: got %b want 0", err_valid); end
        run_to(b + 111);
        checks++; if ({rd_valid, burst_col} !== {1'b1, 10'd3}) begin failures++; $display("FAIL fifo_last: got %b %0d want 1 3", rd_valid, burst_col); end
        run_to(b + 127);
        checks++; if ({rd_valid, burst_col} !== {1'b1, 10'd9}) begin failures++; $display("FAIL fifo_after: got %b %0d want 1 9", rd_valid, burst_col); end
    endtask

    task automatic test_reset_mid_burst();
        int b;
        do_reset(); b = cyc;
        tick(1, 1, 1, 1, 3, 0);
        run_to(b + 80); tick(1, 2, 1, 1, 0, 5);
        run_to(b + 121);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL t6_rd_before: got %b want 1", rd_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_valid, wr_strobe, bank_open} !== 34'd0) begin
            failures++; $display("FAIL t6_async: got %b %b %h want 0 0 0", rd_valid, wr_strobe, bank_open);
        end
        do_reset();
        tick(1, 2, 1, 1, 0, 5);
        checks++; if ({err_valid, err_code} !== {1'b1, 4'd3}) begin failures++; $display("FAIL t6_rd_idle: got %b %0d want 1 3", err_valid, err_code); end
    endtask

    task automatic test_random();
        int v, c, k, bg, ba;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < 45) ? 0 : 1;
            k = $urandom_range(0, 99);
            if (k < 18) c = 1;
            else if (k < 45) c = 2;
            else if (k < 72) c = 3;
            else if (k < 96) c = 4;
            else c = $urandom_range(5, 7);
            k = $urandom_range(0, 2);
            case (k)
                0: begin bg = 0; ba = 0; end
                1: begin bg = 7; ba = 3; end
                default: begin bg = 3; ba = 2; end
            endcase
            tick(v, c, bg, ba, int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)));
            checks++;
            if ({err_valid, err_code} !== {e_err_valid, e_err_code}) begin
                failures++; $display("FAIL rnd_err @%0d: got %b %0d want %b %0d", i, err_valid,
                                     err_code, e_err_valid, e_err_code);
            end
            checks++;
            if (bank_open !== e_open) begin
                failures++; $display("FAIL rnd_open @%0d: got %h want %h", i, bank_open, e_open);
            end
            checks++;
            if ({rd_valid, wr_strobe, burst_bg, burst_ba, burst_col} !== {e_rd, e_wr, e_bg, e_ba, e_col}) begin
                failures++; $display("FAIL rnd_burst @%0d: got %b%b %0d %0d %h want %b%b %0d %0d %h",
                                     i, rd_valid, wr_strobe, burst_bg, burst_ba, burst_col,
                                     e_rd, e_wr, e_bg, e_ba, e_col);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd = '0; cmd_bg = '0; cmd_ba = '0;
        cmd_row = '0; cmd_col = '0;
        test_reset();
        test_read_basic();
        test_trcd();
        test_tras_trc();
        test_state_errors();
        test_bus_conflict();
        test_fifo_full();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
